// File: rtl/uart_pkg.sv
// Shared UART definitions used by uart_rx and uart_tx.
package uart_pkg;

    localparam int unsigned UART_CNT_W     = 14;
    localparam int unsigned UART_DATA_BITS = 8;
    localparam int unsigned UART_IDX_W     = $clog2(UART_DATA_BITS);

    typedef enum logic [4:0] {
        IDLE    = 5'b00001,
        START   = 5'b00010,
        DATA    = 5'b00100,
        STOP    = 5'b01000,
        CLEANUP = 5'b10000
    } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input; both flops reset to RESET_VAL.
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_async;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1, LSB first, idle-high line, mid-bit sampling at CLKS_PER_BIT clocks per bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_rx,
    output logic [UART_DATA_BITS-1:0] o_rx_byte,
    output logic                      o_rx_byte_rdy,
    output logic                      o_rx_busy,
    output logic                      o_rx_frame_err
);

    localparam logic [UART_CNT_W-1:0] CntFull = UART_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [UART_CNT_W-1:0] CntHalf = UART_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [UART_IDX_W-1:0] IdxLast = UART_IDX_W'(UART_DATA_BITS - 1);

    logic                      rx_s;
    logic                      rx_prev_q;
    uart_state_e               state_q, state_d;
    logic [UART_CNT_W-1:0]     cnt_q, cnt_d;
    logic [UART_IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [UART_DATA_BITS-1:0] rx_byte_q, rx_byte_d;
    logic                      rdy_q, rdy_d;
    logic                      err_q, err_d;
    logic                      busy_q, busy_d;

    uart_rx_sync #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk    (i_clk),
        .rst    (i_rst),
        .d_async(i_rx),
        .q      (rx_s)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            rx_byte_q <= '0;
            rdy_q     <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            rx_prev_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            rx_byte_q <= rx_byte_d;
            rdy_q     <= rdy_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            rx_prev_q <= rx_s;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        rx_byte_d = rx_byte_q;
        rdy_d     = 1'b0;
        err_d     = 1'b0;
        busy_d    = busy_q;

        unique case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                // Only a fresh high-to-low edge starts a frame, so a held-low line is ignored.
                if (rx_prev_q && !rx_s) begin
                    state_d = START;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (cnt_q == CntHalf) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    if (!rx_s) begin
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + UART_CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == CntFull) begin
                    cnt_d            = '0;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == IdxLast) begin
                        bit_idx_d = '0;
                        state_d   = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + UART_IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + UART_CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == CntFull) begin
                    cnt_d   = '0;
                    state_d = CLEANUP;
                    if (rx_s) begin
                        rx_byte_d = shift_q;
                        rdy_d     = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + UART_CNT_W'(1);
                end
            end
            CLEANUP: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign o_rx_byte      = rx_byte_q;
    assign o_rx_byte_rdy  = rdy_q;
    assign o_rx_busy      = busy_q;
    assign o_rx_frame_err = err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; a bench-side serializer plays the transmitter.
module tb_uart_rx;

    localparam int unsigned CPB = 16;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] rx_byte;
    logic       rx_rdy;
    logic       rx_busy;
    logic       rx_err;

    int n_vec;
    int n_bad;
    int cyc;
    int start_cyc;
    int rdy_cyc;
    int rdy_cnt;
    int err_cnt;
    int both_cnt;
    int wide_cnt;
    int busy_rise;
    logic prev_rdy;
    logic prev_err;
    logic prev_busy;
    logic [7:0] rx_fifo[$];

    uart_rx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_rx          (rx),
        .o_rx_byte     (rx_byte),
        .o_rx_byte_rdy (rx_rdy),
        .o_rx_busy     (rx_busy),
        .o_rx_frame_err(rx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        rdy_cnt = 0; err_cnt = 0; both_cnt = 0; wide_cnt = 0; busy_rise = 0; rdy_cyc = 0;
        prev_rdy = 1'b0; prev_err = 1'b0; prev_busy = 1'b0;
    end

    // Pulse monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rx_rdy === 1'b1) begin
            rdy_cnt++;
            rx_fifo.push_back(rx_byte);
            if (prev_rdy) wide_cnt++;
            else rdy_cyc = cyc;
        end
        if (rx_err === 1'b1) begin
            err_cnt++;
            if (prev_err) wide_cnt++;
        end
        if (rx_rdy === 1'b1 && rx_err === 1'b1) both_cnt++;
        if (rx_busy === 1'b1 && !prev_busy) busy_rise++;
        prev_rdy  = (rx_rdy === 1'b1);
        prev_err  = (rx_err === 1'b1);
        prev_busy = (rx_busy === 1'b1);
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        idle(CPB);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(data[i]);
        drive_bit(stop_bit);
        rx = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r0, e0, b0, n;
        logic [7:0] exp_bytes[4];
        n_vec = 0;
        n_bad = 0;
        rx    = 1'b1;
        rst   = 1'b1;
        idle(3);
        chk_eq("reset_byte", rx_byte, 8'h00);
        chk_eq("reset_rdy", rx_rdy, 0);
        chk_eq("reset_busy", rx_busy, 0);
        chk_eq("reset_err", rx_err, 0);
        rst = 1'b0;
        idle(4);
        chk_eq("idle_busy", rx_busy, 0);

        // Single frame and latency
        r0 = rdy_cnt; e0 = err_cnt;
        send_frame(8'hA5, 1'b1);
        idle(CPB);
        chk_eq("a5_rdy_count", rdy_cnt - r0, 1);
        chk_eq("a5_byte", rx_byte, 8'hA5);
        chk_eq("a5_no_err", err_cnt - e0, 0);
        chk_eq("a5_busy_low", rx_busy, 0);
        chk_eq("a5_latency_window", ((rdy_cyc - start_cyc) >= 154) && ((rdy_cyc - start_cyc) <= 158), 1);

        // Back-to-back stream
        exp_bytes = '{8'h00, 8'hFF, 8'h55, 8'h3C};
        rx_fifo.delete();
        e0 = err_cnt;
        for (int i = 0; i < 4; i++) send_frame(exp_bytes[i], 1'b1);
        idle(CPB);
        chk_eq("b2b_count", rx_fifo.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk_eq($sformatf("b2b_byte%0d", i), (rx_fifo.size() > 0) ? rx_fifo.pop_front() : 9'h1ff,
                   exp_bytes[i]);
        end
        chk_eq("b2b_no_err", err_cnt - e0, 0);

        // Glitch shorter than half a bit
        r0 = rdy_cnt; e0 = err_cnt; b0 = busy_rise;
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        n = 0;
        while (rx_busy === 1'b1 && n < CPB / 2 + 3) begin
            idle(1);
            n++;
        end
        chk_eq("glitch_busy_clear", rx_busy, 0);
        chk_eq("glitch_busy_seen", busy_rise - b0, 1);
        idle(2 * CPB);
        chk_eq("glitch_no_rdy", rdy_cnt - r0, 0);
        chk_eq("glitch_no_err", err_cnt - e0, 0);

        // Framing error keeps the previous byte
        r0 = rdy_cnt; e0 = err_cnt;
        send_frame(8'h12, 1'b0);
        idle(CPB);
        chk_eq("ferr_err_count", err_cnt - e0, 1);
        chk_eq("ferr_no_rdy", rdy_cnt - r0, 0);
        chk_eq("ferr_byte_held", rx_byte, 8'h3C);

        // Break, then recovery
        r0 = rdy_cnt; e0 = err_cnt; b0 = busy_rise;
        rx = 1'b0;
        idle(30 * CPB);
        chk_eq("break_busy_low", rx_busy, 0);
        rx = 1'b1;
        idle(2 * CPB);
        chk_eq("break_err_count", err_cnt - e0, 1);
        chk_eq("break_no_rdy", rdy_cnt - r0, 0);
        chk_eq("break_one_start", busy_rise - b0, 1);
        send_frame(8'h81, 1'b1);
        idle(CPB);
        chk_eq("break_recover_byte", rx_byte, 8'h81);
        chk_eq("break_recover_rdy", rdy_cnt - r0, 1);

        // Reset during data bit 3 of 8'hC3
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b0);
        rx = 1'b0;
        idle(CPB / 2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        rx  = 1'b1;
        r0 = rdy_cnt; e0 = err_cnt; b0 = busy_rise;
        chk_eq("rst_mid_byte", rx_byte, 8'h00);
        chk_eq("rst_mid_busy", rx_busy, 0);
        chk_eq("rst_mid_rdy", rx_rdy, 0);
        chk_eq("rst_mid_err", rx_err, 0);
        idle(12 * CPB);
        chk_eq("rst_quiet_rdy", rdy_cnt - r0, 0);
        chk_eq("rst_quiet_err", err_cnt - e0, 0);
        chk_eq("rst_quiet_busy", busy_rise - b0, 0);
        send_frame(8'h7E, 1'b1);
        idle(CPB);
        chk_eq("rst_next_byte", rx_byte, 8'h7E);
        chk_eq("rst_next_rdy", rdy_cnt - r0, 1);

        chk_eq("never_rdy_and_err", both_cnt, 0);
        chk_eq("pulses_one_cycle", wide_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
